// File: rtl/tcb_lib_mem.sv
// tcb_lib_mem: single-port TCB memory subordinate with fixed response latency.
//
// Always ready once reset is released, so it accepts one request per cycle.
// A request is checked for errors: address outside the memory, an address
// that is not aligned to its transfer size, or a transfer size wider than
// the bus. Requests that pass the check write the enabled byte lanes, or
// read the whole addressed word. Each response (read data and error flag)
// travels through a DLY-stage pipeline and appears DLY cycles after its
// request. Reset clears the pipeline but leaves the memory array untouched.
//
// Parameters:
//   ABW - address bus width        DBW - data bus width
//   SLW - byte-lane width          DLY - response latency, 1..4
//   SIZ - memory size in bytes (power of 2, multiple of DBW/SLW)
// Ports:
//   clk, rst (async, active-low)
//   tcb_vld/tcb_rdy      - request handshake
//   tcb_wen, tcb_adr, tcb_siz, tcb_ben, tcb_wdt - request fields
//   tcb_rdt, tcb_err     - response, DLY cycles after the transfer
module tcb_lib_mem #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8,
  parameter int unsigned DLY = 1,
  parameter int unsigned SIZ = 4096
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   tcb_vld,
  output logic                                   tcb_rdy,
  input  logic                                   tcb_wen,
  input  logic [ABW-1:0]                         tcb_adr,
  input  logic [$clog2($clog2(DBW/SLW)+1)-1:0]   tcb_siz,
  input  logic [DBW/SLW-1:0]                     tcb_ben,
  input  logic [DBW-1:0]                         tcb_wdt,
  output logic [DBW-1:0]                         tcb_rdt,
  output logic                                   tcb_err
);

  localparam int unsigned BEW = DBW / SLW;
  localparam int unsigned BLG = $clog2(BEW);
  localparam int unsigned AMW = $clog2(SIZ);
  localparam int unsigned WDS = SIZ / BEW;
  localparam int unsigned IXW = AMW - BLG;

  logic           xfer;
  logic           adr_oor;
  logic           adr_mis;
  logic           siz_bad;
  logic           req_err;
  logic [IXW-1:0] idx;

  // Ready follows the reset input directly, so the first rising edge with
  // reset released already accepts a transfer.
  assign tcb_rdy = rst;

  always_comb begin
    xfer    = tcb_vld & tcb_rdy;
    idx     = tcb_adr[AMW-1:BLG];
    // Any set bit above the memory range means the address is out of bounds;
    // this also keeps SIZ from aliasing to word 0.
    adr_oor = 1'b0;
    for (int unsigned i = AMW; i < ABW; i++) begin
      if (tcb_adr[i]) adr_oor = 1'b1;
    end
    siz_bad = (32'(tcb_siz) > BLG);
    // Misaligned when any of the low tcb_siz address bits is set.
    adr_mis = 1'b0;
    for (int unsigned i = 0; i < BLG; i++) begin
      if ((i < 32'(tcb_siz)) && tcb_adr[i]) adr_mis = 1'b1;
    end
    req_err = adr_oor | adr_mis | siz_bad;
  end

  // Memory array: no reset, contents persist across reset.
  logic [DBW-1:0] mem_q [WDS];

  always_ff @(posedge clk) begin
    if (xfer && tcb_wen && !req_err) begin
      for (int unsigned b = 0; b < BEW; b++) begin
        if (tcb_ben[b]) mem_q[idx][b*SLW +: SLW] <= tcb_wdt[b*SLW +: SLW];
      end
    end
  end

  // Response pipeline; stage DLY-1 drives the outputs.
  logic [DLY-1:0] vld_q;
  logic [DLY-1:0] err_q;
  logic [DBW-1:0] rdt_q [DLY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int unsigned i = 0; i < DLY; i++) begin
        rdt_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= xfer;
      err_q[0] <= xfer & req_err;
      rdt_q[0] <= (xfer && !tcb_wen && !req_err) ? mem_q[idx] : '0;
      for (int unsigned i = 1; i < DLY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        rdt_q[i] <= rdt_q[i-1];
      end
    end
  end

  assign tcb_rdt = vld_q[DLY-1] ? rdt_q[DLY-1] : '0;
  assign tcb_err = vld_q[DLY-1] & err_q[DLY-1];

endmodule

// File: tb/tb_tcb_lib_mem.sv
// Bench for tcb_lib_mem: three instances (DLY=1, 2, 3) share one request bus.
// The DLY=1 instance is exercised by a vector table; the DLY=3 and DLY=2
// instances cover pipelined back-to-back reads and reset during operation.
module tb_tcb_lib_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2;
  logic        vld, wen;
  logic [31:0] adr, wdt;
  logic [1:0]  siz;
  logic [3:0]  ben;

  logic        rdy1, rdy2, rdy3, err1, err2, err3;
  logic [31:0] rdt1, rdt2, rdt3;

  tcb_lib_mem #(.DLY(1)) dut1 (
    .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy1), .tcb_wen(wen),
    .tcb_adr(adr), .tcb_siz(siz), .tcb_ben(ben), .tcb_wdt(wdt),
    .tcb_rdt(rdt1), .tcb_err(err1)
  );
  tcb_lib_mem #(.DLY(2)) dut2 (
    .clk(clk), .rst(rst2), .tcb_vld(vld), .tcb_rdy(rdy2), .tcb_wen(wen),
    .tcb_adr(adr), .tcb_siz(siz), .tcb_ben(ben), .tcb_wdt(wdt),
    .tcb_rdt(rdt2), .tcb_err(err2)
  );
  tcb_lib_mem #(.DLY(3)) dut3 (
    .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy3), .tcb_wen(wen),
    .tcb_adr(adr), .tcb_siz(siz), .tcb_ben(ben), .tcb_wdt(wdt),
    .tcb_rdt(rdt3), .tcb_err(err3)
  );

  typedef struct {
    logic        vld;
    logic        wen;
    logic [31:0] adr;
    logic [1:0]  siz;
    logic [3:0]  ben;
    logic [31:0] wdt;
    logic [31:0] rdt;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic v, input logic w, input logic [31:0] a,
                              input logic [1:0] s, input logic [3:0] b,
                              input logic [31:0] d, input logic [31:0] r,
                              input logic e);
    vec_t t;
    t.vld = v; t.wen = w; t.adr = a; t.siz = s; t.ben = b; t.wdt = d;
    t.rdt = r; t.err = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [1:0] s, input logic [3:0] b, input logic [31:0] d);
    vld = v; wen = w; adr = a; siz = s; ben = b; wdt = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // write/read fields: vld wen adr siz ben wdt | expected rdt err
    tbl.push_back(mk(1, 1, 32'h000, 2, 4'hF, 32'h01234567, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h000, 2, 4'hF, 32'h0, 32'h01234567, 0));
    tbl.push_back(mk(1, 1, 32'h000, 2, 4'hF, 32'hFFFFFFFF, 32'h0, 0));
    tbl.push_back(mk(1, 1, 32'h000, 0, 4'h1, 32'h000000AA, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h000, 2, 4'hF, 32'h0, 32'hFFFFFFAA, 0));
    tbl.push_back(mk(1, 0, 32'h011, 2, 4'hF, 32'h0, 32'h0, 1));        // misaligned
    tbl.push_back(mk(0, 0, 32'h000, 2, 4'hF, 32'h0, 32'h0, 0));        // idle: err drops
    tbl.push_back(mk(1, 0, 32'h1000, 2, 4'hF, 32'h0, 32'h0, 1));       // adr == SIZ
    tbl.push_back(mk(1, 1, 32'h1000, 2, 4'hF, 32'hDEADBEEF, 32'h0, 1));
    tbl.push_back(mk(1, 0, 32'h000, 2, 4'hF, 32'h0, 32'hFFFFFFAA, 0)); // no alias
    tbl.push_back(mk(1, 1, 32'h008, 2, 4'hF, 32'hCAFEBABE, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h008, 2, 4'hF, 32'h0, 32'hCAFEBABE, 0));
    tbl.push_back(mk(1, 1, 32'hFFC, 2, 4'hF, 32'h5A5A1234, 32'h0, 0)); // last word
    tbl.push_back(mk(1, 0, 32'hFFC, 2, 4'hF, 32'h0, 32'h5A5A1234, 0));
    tbl.push_back(mk(1, 0, 32'h000, 3, 4'hF, 32'h0, 32'h0, 1));        // siz too wide
    tbl.push_back(mk(1, 1, 32'h004, 2, 4'hF, 32'h00000011, 32'h0, 0));
    tbl.push_back(mk(1, 1, 32'h008, 2, 4'hF, 32'h00000022, 32'h0, 0));
    tbl.push_back(mk(1, 1, 32'h00C, 2, 4'hF, 32'h00000033, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h004, 2, 4'h0, 32'h0, 32'h00000011, 0)); // ben ignored
    tbl.push_back(mk(1, 1, 32'h002, 1, 4'hC, 32'hBEEF0000, 32'h0, 0)); // halfword
    tbl.push_back(mk(1, 0, 32'h000, 2, 4'hF, 32'h0, 32'hBEEFFFAA, 0));
    tbl.push_back(mk(1, 1, 32'h001, 1, 4'hF, 32'h00000000, 32'h0, 1)); // misaligned wr
    tbl.push_back(mk(1, 0, 32'h003, 0, 4'h8, 32'h0, 32'hBEEFFFAA, 0)); // byte read

    rst = 1'b0; rst2 = 1'b0;
    drive(0, 0, 32'h0, 2, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset rdy1", 32'(rdy1), 32'h0);
    chk("reset rdy2", 32'(rdy2), 32'h0);
    chk("reset rdy3", 32'(rdy3), 32'h0);
    chk("reset rdt1", rdt1, 32'h0);
    chk("reset err1", 32'(err1), 32'h0);
    chk("reset rdt3", rdt3, 32'h0);
    #2;
    rst = 1'b1; rst2 = 1'b1;
    #1;
    chk("rdy1 after release", 32'(rdy1), 32'h1);

    // First table row lands on the first edge with reset high.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vld, tbl[i].wen, tbl[i].adr, tbl[i].siz, tbl[i].ben, tbl[i].wdt);
      step();
      chk($sformatf("vec%0d rdt", i), rdt1, tbl[i].rdt);
      chk($sformatf("vec%0d err", i), 32'(err1), 32'(tbl[i].err));
      chk($sformatf("vec%0d rdy", i), 32'(rdy1), 32'h1);
    end

    // DLY=3: back-to-back reads, responses on consecutive cycles.
    drive(0, 0, 32'h0, 2, 4'hF, 32'h0);
    repeat (4) step();
    drive(1, 0, 32'h004, 2, 4'hF, 32'h0); step(); chk("d3 c1", rdt3, 32'h0);
    drive(1, 0, 32'h008, 2, 4'hF, 32'h0); step(); chk("d3 c2", rdt3, 32'h0);
    drive(1, 0, 32'h00C, 2, 4'hF, 32'h0); step(); chk("d3 c3 rdt", rdt3, 32'h11);
    chk("d3 c3 err", 32'(err3), 32'h0);
    drive(0, 0, 32'h0, 2, 4'hF, 32'h0);
    step(); chk("d3 c4", rdt3, 32'h22);
    step(); chk("d3 c5", rdt3, 32'h33);
    step(); chk("d3 c6", rdt3, 32'h0);

    // DLY=2: reset while responses are in flight.
    repeat (2) step();
    drive(1, 0, 32'h004, 2, 4'hF, 32'h0); step(); chk("d2 c1", rdt2, 32'h0);
    drive(1, 0, 32'h008, 2, 4'hF, 32'h0); step(); chk("d2 c2", rdt2, 32'h11);
    drive(0, 0, 32'h0, 2, 4'hF, 32'h0);
    #1 rst2 = 1'b0;
    #1;
    chk("d2 rst rdt", rdt2, 32'h0);
    chk("d2 rst err", 32'(err2), 32'h0);
    chk("d2 rst rdy", 32'(rdy2), 32'h0);
    step();
    #2 rst2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("d2 flushed rdt %0d", i), rdt2, 32'h0);
      chk($sformatf("d2 flushed err %0d", i), 32'(err2), 32'h0);
    end
    chk("d2 rdy after release", 32'(rdy2), 32'h1);
    drive(1, 0, 32'h00C, 2, 4'hF, 32'h0); step(); chk("d2 rd c1", rdt2, 32'h0);
    drive(1, 0, 32'h1000, 2, 4'hF, 32'h0); step(); chk("d2 rd c2", rdt2, 32'h33);
    drive(0, 0, 32'h0, 2, 4'hF, 32'h0);
    step(); chk("d2 err pulse", 32'(err2), 32'h1);
    chk("d2 err rdt", rdt2, 32'h0);
    step(); chk("d2 err cleared", 32'(err2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcb_lib_mem.md
TCB_LIB_MEM -- requirements
Module: tcb_lib_mem

Interface
REQ-001 SHALL have parameter ABW, default 32, address bus width in bits.
REQ-002 SHALL have parameter DBW, default 32, data bus width in bits.
REQ-003 SHALL have parameter SLW, default 8, byte-lane width; BEW = DBW/SLW lanes.
REQ-004 SHALL have parameter DLY, default 1, read/response latency in cycles; legal range 1..4.
REQ-005 SHALL have parameter SIZ, default 4096, memory size in bytes; a power of 2 and a multiple of BEW.
REQ-006 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port tcb_vld  input  1  request valid from manager.
REQ-009 SHALL have port tcb_rdy  output  1  subordinate ready.
REQ-010 SHALL have port tcb_wen  input  1  write enable (1 write, 0 read).
REQ-011 SHALL have port tcb_adr  input  ABW  byte address.
REQ-012 SHALL have port tcb_siz  input  $clog2($clog2(BEW)+1)  transfer size, log2 of byte count.
REQ-013 SHALL have port tcb_ben  input  BEW  byte-lane enables.
REQ-014 SHALL have port tcb_wdt  input  DBW  write data.
REQ-015 SHALL have port tcb_rdt  output  DBW  read data, valid DLY cycles after transfer.
REQ-016 SHALL have port tcb_err  output  1  error response, valid DLY cycles after transfer.

Function
REQ-017 SHALL define a transfer as tcb_vld & tcb_rdy sampled at a rising clk edge.
REQ-018 SHALL drive tcb_rdy = 1 in every cycle after reset release, with no backpressure; tcb_rdy = 0 while rst is low.
REQ-019 SHALL accept one transfer per cycle, back-to-back, without bubbles.
REQ-020 SHALL store SIZ bytes as SIZ/BEW words indexed by tcb_adr[$clog2(SIZ)-1:$clog2(BEW)].
REQ-021 SHALL flag an error transfer when tcb_adr >= SIZ, or tcb_adr is not a multiple of 2**tcb_siz, or tcb_siz > $clog2(BEW).
REQ-022 SHALL, on a non-error write transfer, update exactly the byte lanes with tcb_ben = 1 at that edge; other lanes keep their contents.
REQ-023 SHALL suppress all memory updates on an error write transfer.
REQ-024 SHALL sample the full addressed word at a non-error read transfer edge and present it on tcb_rdt exactly DLY cycles later, all lanes, regardless of tcb_ben.
REQ-025 SHALL return tcb_rdt = 0 for error transfers and for write transfers.
REQ-026 SHALL assert tcb_err = 1 for exactly one cycle, DLY cycles after an error transfer; otherwise tcb_err = 0.
REQ-027 SHALL implement the DLY latency as a DLY-stage shift pipeline of {valid, err, rdt}; stage 0 is loaded at the transfer edge.
REQ-028 SHALL hold tcb_rdt and tcb_err at 0 in cycles whose pipeline output stage carries no transfer.
REQ-029 SHALL return, for a read transfer one cycle after a write to the same word, the newly written data (write-before-read ordering in memory).
REQ-030 SHALL return, for a read and a write to the same word in the same cycle (impossible on one port), no additional case; a single request per edge is processed.
REQ-031 SHALL handle the address wrap boundary: tcb_adr = SIZ-BEW is legal, tcb_adr = SIZ is an error with no alias to word 0.

Reset
REQ-032 SHALL, on rst low, asynchronously clear all pipeline valid/err/rdt stages, so tcb_rdt = 0, tcb_err = 0, tcb_rdy = 0.
REQ-033 SHALL leave memory contents unchanged by reset; contents are undefined at power-up.
REQ-034 SHALL discard all in-flight responses when reset is asserted mid-operation; no response emerges after reset release.
REQ-035 SHALL accept transfers from the first rising edge at which rst is high.

Verification
REQ-036 SHALL verify: DLY=1, write adr 0x00 wdt 0x01234567 ben 1111, then read 0x00 -> tcb_rdt = 0x01234567 one cycle after the read transfer, tcb_err = 0.
REQ-037 SHALL verify: write 0x00 0xFFFFFFFF ben 1111, then write 0x00 0x000000AA ben 0001 siz 0, read 0x00 -> 0xFFFFFFAA.
REQ-038 SHALL verify: DLY=3, back-to-back reads of 0x04, 0x08, 0x0C preloaded 0x11,0x22,0x33 -> responses on three consecutive cycles starting 3 cycles after the first transfer, in order.
REQ-039 SHALL verify: read adr 0x11 siz 2 (misaligned) and read adr SIZ -> tcb_err = 1, tcb_rdt = 0; write adr SIZ wdt 0xDEADBEEF -> err = 1 and a following read of 0x00 unchanged.
REQ-040 SHALL verify: DLY=2, read transfer then rst low one cycle later -> tcb_rdt, tcb_err, tcb_rdy read 0 immediately and no response appears after reset release.
REQ-041 SHALL verify: write 0x08 0xCAFEBABE then read 0x08 on the next cycle -> 0xCAFEBABE.
